// File: rtl/fir_3tap_pkg.sv
// Shared types and constants for the 3-tap FIR inverse (deconvolution) block.
package fir_3tap_pkg;

    // Operating mode of the inverter: decoding normally, or halted on a decode error.
    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    localparam int XW   = 8;     // recovered sample width
    localparam int YW   = 16;    // filtered input sample width
    localparam int AW   = 18;    // internal arithmetic width, wide enough for y - h1 - h2
    localparam int XMIN = -128;  // smallest representable recovered sample
    localparam int XMAX = 127;   // largest representable recovered sample

endpackage

// File: rtl/fir_3tap_inv_chk.sv
// Combinational decode datapath: undoes the input scaling, subtracts the two
// previous recovered samples and flags results that cannot be a valid x sample.
module fir_3tap_inv_chk
    import fir_3tap_pkg::*;
#(
    parameter int COEF_SHIFT = 0
) (
    input  logic signed [YW-1:0] y_in,
    input  logic signed [XW-1:0] h1,
    input  logic signed [XW-1:0] h2,
    output logic signed [AW-1:0] r,
    output logic                 err
);

    localparam logic signed [AW-1:0] R_MIN = AW'(XMIN);
    localparam logic signed [AW-1:0] R_MAX = AW'(XMAX);

    logic [YW-1:0]        low_mask;
    logic signed [AW-1:0] y_ext;
    logic signed [AW-1:0] s;
    logic signed [AW-1:0] h1_ext;
    logic signed [AW-1:0] h2_ext;
    logic                 misaligned;
    logic                 out_of_range;

    // Bits below the scaling point must be zero for a legitimately scaled sum.
    genvar gi;
    generate
        for (gi = 0; gi < YW; gi++) begin : g_mask
            assign low_mask[gi] = (gi < COEF_SHIFT);
        end
    endgenerate

    assign y_ext  = {{(AW-YW){y_in[YW-1]}}, y_in};
    assign h1_ext = {{(AW-XW){h1[XW-1]}}, h1};
    assign h2_ext = {{(AW-XW){h2[XW-1]}}, h2};

    // Remove the 2^COEF_SHIFT gain, then peel off the two older taps.
    assign s = y_ext >>> COEF_SHIFT;
    assign r = s - h1_ext - h2_ext;

    assign misaligned   = |(y_in & low_mask);
    assign out_of_range = (r < R_MIN) || (r > R_MAX);
    assign err          = misaligned || out_of_range;

endmodule

// File: rtl/fir_3tap_inv.sv
// Inverse of a 3-tap moving-sum FIR: recovers x[n] from y[n] using the two
// previously recovered samples, with a valid/ready stream on each side and a
// sticky fault state on decode errors.
// Optional feature: define FIR_3TAP_INV_CNT_EN to add the 16-bit sample_cnt
// output counting completed output handshakes.
module fir_3tap_inv
    import fir_3tap_pkg::*;
#(
    parameter int COEF_SHIFT = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [YW-1:0] y_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic signed [XW-1:0] x_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 fault,
    input  logic                 clr_fault
`ifdef FIR_3TAP_INV_CNT_EN
    ,
    output logic [15:0]          sample_cnt
`endif
);

    state_t               state_reg;
    state_t               state_next;
    logic signed [XW-1:0] h1_reg;
    logic signed [XW-1:0] h2_reg;
    logic signed [XW-1:0] x_out_reg;
    logic                 out_valid_reg;
    logic                 fault_reg;

    logic signed [AW-1:0] r;
    logic                 err;
    logic                 accept;
    logic                 load;
    logic                 leave_fault;
    logic                 unused_r_hi;

    fir_3tap_inv_chk #(
        .COEF_SHIFT(COEF_SHIFT)
    ) u_chk (
        .y_in (y_in),
        .h1   (h1_reg),
        .h2   (h2_reg),
        .r    (r),
        .err  (err)
    );

    // Upper bits of r only matter to the range check inside the checker.
    assign unused_r_hi = ^r[AW-1:XW];

    // Accept only while running and the output register is free or draining now.
    assign in_ready    = (state_reg == RUN) && (!out_valid_reg || out_ready);
    assign accept      = in_valid && in_ready;
    assign load        = accept && !err;
    assign leave_fault = (state_reg == FAULT) && clr_fault;

    assign x_out     = x_out_reg;
    assign out_valid = out_valid_reg;
    assign fault     = fault_reg;

    // Next-state logic: a bad accept halts decoding, clr_fault resumes it.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN:     if (accept && err) state_next = FAULT;
            FAULT:   if (clr_fault)     state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // State, history, output register and sticky fault flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= RUN;
            h1_reg        <= '0;
            h2_reg        <= '0;
            x_out_reg     <= '0;
            out_valid_reg <= 1'b0;
            fault_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;

            // A new sample replaces the drained one in the same cycle (no bubble).
            if (load) begin
                x_out_reg     <= r[XW-1:0];
                out_valid_reg <= 1'b1;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end

            // History only advances on good samples; resync starts from zero.
            if (load) begin
                h1_reg <= r[XW-1:0];
                h2_reg <= h1_reg;
            end else if (leave_fault) begin
                h1_reg <= '0;
                h2_reg <= '0;
            end

            if (accept && err) begin
                fault_reg <= 1'b1;
            end else if (leave_fault) begin
                fault_reg <= 1'b0;
            end
        end
    end

`ifdef FIR_3TAP_INV_CNT_EN
    logic [15:0] sample_cnt_reg;

    // Counts completed output handshakes; survives clr_fault, wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_cnt_reg <= '0;
        end else if (out_valid_reg && out_ready) begin
            sample_cnt_reg <= sample_cnt_reg + 16'd1;
        end
    end

    assign sample_cnt = sample_cnt_reg;
`endif

endmodule

// File: doc/fir_3tap_inv.md
FIR_3TAP_INV -- requirements
Module: fir_3tap_inv

Interface
REQ-001 SHALL have parameter COEF_SHIFT, default 0, range 0..7: input scaling, y_in = 2^COEF_SHIFT * (x[n]+x[n-1]+x[n-2]).
REQ-002 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port y_in  input  16  signed 3-tap filter output sample to invert.
REQ-005 SHALL have port in_valid  input  1  y_in valid.
REQ-006 SHALL have port in_ready  output  1  block accepts y_in this cycle.
REQ-007 SHALL have port x_out  output  8  signed recovered input sample.
REQ-008 SHALL have port out_valid  output  1  x_out valid.
REQ-009 SHALL have port out_ready  input  1  downstream accepts x_out.
REQ-010 SHALL have port fault  output  1  sticky decode-error flag.
REQ-011 SHALL have port clr_fault  input  1  one-cycle request to leave FAULT and resynchronise.

Function
REQ-012 SHALL implement states RUN and FAULT; RUN -> FAULT on decode error; FAULT -> RUN on clr_fault; clr_fault in RUN ignored.
REQ-013 SHALL set in_ready = (state==RUN) and (!out_valid or out_ready), combinationally.
REQ-014 SHALL, on accept (in_valid and in_ready), compute s = y_in arithmetic-right-shifted by COEF_SHIFT and r = s - h1 - h2 in 18-bit signed, h1/h2 being the previous two recovered samples.
REQ-015 SHALL flag decode error when any low COEF_SHIFT bits of y_in are nonzero or r lies outside [-128, 127].
REQ-016 SHALL, on error-free accept, load x_out = r[7:0], set out_valid the next cycle (latency 1), and shift h2 <= h1, h1 <= r.
REQ-017 SHALL, on erroneous accept, produce no output, leave h1/h2 unchanged, enter FAULT and set fault the next cycle.
REQ-018 SHALL hold x_out and out_valid stable while out_valid and !out_ready.
REQ-019 SHALL clear out_valid on out_ready unless a new sample is accepted the same cycle, in which case the new sample loads without a bubble.
REQ-020 SHALL let a pending output drain in FAULT; no new accepts in FAULT.
REQ-021 SHALL, on clr_fault in FAULT, clear h1, h2 and fault, and return to RUN the next cycle.

Reset
REQ-022 SHALL, on rst, set state RUN, h1=h2=0, x_out=0, out_valid=0, fault=0, discarding any pending output.
REQ-023 SHALL give rst priority over all other inputs, including clr_fault and accepts in the same cycle.

Configuration
REQ-024 SHALL, with FIR_3TAP_INV_CNT_EN defined, add output sample_cnt (16 bits), incrementing per completed output handshake, wrapping 0xFFFF -> 0x0000, reset to 0, unaffected by clr_fault.
REQ-025 SHALL, without FIR_3TAP_INV_CNT_EN, omit sample_cnt port and logic; all other behaviour identical.

Structure
REQ-026 SHALL place in shared package fir_3tap_pkg: state enum (RUN, FAULT), widths XW=8, YW=16, AW=18, and limits XMIN=-128, XMAX=127.
REQ-027 SHALL use one sub-module fir_3tap_inv_chk: combinational shift, subtraction, range/alignment check, producing r and err.

Verification
REQ-028 SHALL check: after reset, y_in 5, 2, 102 (COEF_SHIFT=0), out_ready=1 -> x_out 5, -3, 100, each one cycle after accept.
REQ-029 SHALL check: after reset, y_in 200 -> no out_valid, fault=1, in_ready=0; clr_fault -> fault=0, in_ready=1; then y_in 7 -> x_out 7.
REQ-030 SHALL check: COEF_SHIFT=2, y_in 0x0014 -> x_out 5; next y_in 0x0015 -> fault, history unchanged.
REQ-031 SHALL check: out_ready low 3 cycles with out_valid=1 -> x_out constant, in_ready=0; out_ready high plus in_valid same cycle -> back-to-back outputs, no bubble.
REQ-032 SHALL check: rst after y_in 10, 10 -> out_valid=0; then y_in -4 -> x_out -4 (history cleared).
REQ-033 SHALL check, with FIR_3TAP_INV_CNT_EN: 65537 outputs of y_in 0 -> sample_cnt = 1 after wrap.
